stream_word_packer: RTL and testbench



---
 rtl/stream_pkg.sv | 18 +
 rtl/stream_word_packer.sv | 84 ++++++++
 tb/tb_stream_word_packer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/stream_pkg.sv
// stream_pkg
//   Shared definitions for the word-to-beat packing datapath.
//   DEF_DATA_WIDTH / DEF_PACK_RATIO : default input word width and words per beat
//   KEEP_W                          : one keep bit per lane of a packed beat
//   beat_t                          : packed output beat {data, keep, last}
package stream_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_PACK_RATIO = 4;
    localparam int KEEP_W         = DEF_PACK_RATIO;

    typedef struct packed {
        logic [DEF_DATA_WIDTH*DEF_PACK_RATIO-1:0] data;
        logic [KEEP_W-1:0]                        keep;
        logic                                     last;
    } beat_t;

endpackage

// File: rtl/stream_word_packer.sv
// stream_word_packer
//   Pops DATA_WIDTH words from an upstream FIFO (valid/ready) and packs
//   PACK_RATIO consecutive words into one registered wide beat, lane 0 in the
//   LSBs. A last marker closes the beat early; unfilled lanes are zero and
//   their keep bits clear.
// Ports
//   i_clk, i_rst           : clock (rising edge), async active-high reset
//   i_valid_s, i_datain,
//   i_last_s, o_ready_s    : input word handshake, last qualified by valid
//   o_valid_m, o_dataout,
//   o_keep, o_last_m,
//   i_ready_m              : packed beat handshake toward the wide datapath
module stream_word_packer
    import stream_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int PACK_RATIO = DEF_PACK_RATIO,
    parameter int CW         = $clog2(PACK_RATIO)
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_valid_s,
    input  logic [DATA_WIDTH-1:0]          i_datain,
    input  logic                           i_last_s,
    output logic                           o_ready_s,
    output logic                           o_valid_m,
    output logic [DATA_WIDTH*PACK_RATIO-1:0] o_dataout,
    output logic [PACK_RATIO-1:0]          o_keep,
    output logic                           o_last_m,
    input  logic                           i_ready_m
);

    logic [CW-1:0]                         cnt;
    logic [PACK_RATIO-1:0][DATA_WIDTH-1:0] acc;
    logic [PACK_RATIO-1:0][DATA_WIDTH-1:0] acc_nxt;
    logic [PACK_RATIO-1:0]                 keep_nxt;
    logic                                  in_xfer;
    logic                                  out_xfer;
    logic                                  beat_done;

    // Accept whenever the single output register is free or draining now.
    assign o_ready_s = !o_valid_m || i_ready_m;
    assign in_xfer   = i_valid_s && o_ready_s;
    assign out_xfer  = o_valid_m && i_ready_m;
    assign beat_done = in_xfer && (i_last_s || cnt == CW'(PACK_RATIO - 1));

    // Accumulator with the incoming word merged in. Lanes fill strictly in
    // order from lane 0, so the keep mask is every lane up to and including cnt.
    for (genvar j = 0; j < PACK_RATIO; j++) begin : g_lane
        assign acc_nxt[j]  = (in_xfer && cnt == CW'(j)) ? i_datain : acc[j];
        assign keep_nxt[j] = (CW'(j) <= cnt);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt       <= '0;
            acc       <= '0;
            o_valid_m <= 1'b0;
            o_dataout <= '0;
            o_keep    <= '0;
            o_last_m  <= 1'b0;
        end else begin
            // Clearing on completion keeps unfilled lanes of the next beat zero.
            if (beat_done) begin
                cnt <= '0;
                acc <= '0;
            end else if (in_xfer) begin
                cnt <= cnt + 1'b1;
                acc <= acc_nxt;
            end

            // Completion wins over drain so a reload keeps valid high.
            if (beat_done) begin
                o_valid_m <= 1'b1;
                o_dataout <= acc_nxt;
                o_keep    <= keep_nxt;
                o_last_m  <= i_last_s;
            end else if (out_xfer) begin
                o_valid_m <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_word_packer.sv
module tb_stream_word_packer;
    import stream_pkg::*;

    localparam int DW = DEF_DATA_WIDTH;
    localparam int PR = DEF_PACK_RATIO;

    logic               i_clk = 1'b0;
    logic               i_rst = 1'b1;
    logic               i_valid_s = 1'b0;
    logic [DW-1:0]      i_datain = '0;
    logic               i_last_s = 1'b0;
    logic               o_ready_s;
    logic               o_valid_m;
    logic [DW*PR-1:0]   o_dataout;
    logic [PR-1:0]      o_keep;
    logic               o_last_m;
    logic               i_ready_m = 1'b1;

    int n_vec  = 0;
    int n_miss = 0;

    stream_word_packer dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_valid_s (i_valid_s),
        .i_datain  (i_datain),
        .i_last_s  (i_last_s),
        .o_ready_s (o_ready_s),
        .o_valid_m (o_valid_m),
        .o_dataout (o_dataout),
        .o_keep    (o_keep),
        .o_last_m  (o_last_m),
        .i_ready_m (i_ready_m)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // ---------------- behavioural model + per-cycle compare ----------------
    // Accepted words collect in a list; a list of PR words or one ending in
    // last becomes an expected beat. Beats queue until the downstream takes
    // them; the one at the head is what the outputs must show.
    beat_t         exp_q[$];
    logic [DW-1:0] part[$];
    beat_t         shown = '0;

    always @(negedge i_clk) begin
        beat_t b;
        logic  ev, rdy;
        if (i_rst) begin
            exp_q.delete();
            part.delete();
            shown = '0;
            chk("rst_valid", 128'(o_valid_m), 128'(0));
            chk("rst_data",  128'(o_dataout), 128'(0));
            chk("rst_keep",  128'(o_keep),    128'(0));
            chk("rst_last",  128'(o_last_m),  128'(0));
        end else begin
            ev = exp_q.size() > 0;
            if (ev) shown = exp_q[0];
            rdy = !ev || i_ready_m;
            chk("valid", 128'(o_valid_m), 128'(ev));
            chk("ready", 128'(o_ready_s), 128'(rdy));
            chk("data",  128'(o_dataout), 128'(shown.data));
            chk("keep",  128'(o_keep),    128'(shown.keep));
            chk("last",  128'(o_last_m),  128'(shown.last));
            if (ev && i_ready_m) void'(exp_q.pop_front());
            if (i_valid_s && rdy) begin
                part.push_back(i_datain);
                if (part.size() == PR || i_last_s) begin
                    b = '0;
                    foreach (part[k]) b.data[k*DW +: DW] = part[k];
                    b.keep = PR'((1 << part.size()) - 1);
                    b.last = i_last_s;
                    exp_q.push_back(b);
                    part.delete();
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called just after a rising edge; returns just after the edge that
    // accepted the word, leaving the word presented (caller idles if done).
    task automatic push_word(input logic [DW-1:0] d, input logic l);
        bit ok = 0;
        i_valid_s = 1'b1;
        i_datain  = d;
        i_last_s  = l;
        for (int t = 0; t < 50; t++) begin
            @(negedge i_clk);
            if (o_ready_s) begin ok = 1; break; end
            @(posedge i_clk);
        end
        if (!ok) chk("push_timeout", 128'(0), 128'(1));
        @(posedge i_clk); #1;
    endtask

    task automatic idle();
        i_valid_s = 1'b0;
        i_last_s  = 1'b0;
    endtask

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } fword_t;

    initial begin
        fword_t fq[$];
        logic   take;
        int     seq;

        repeat (2) @(posedge i_clk);
        #1 i_rst = 1'b0;

        // Full beat, valid exactly one cycle
        push_word(32'h11, 0); push_word(32'h22, 0);
        push_word(32'h33, 0); push_word(32'h44, 0);
        idle();
        chk("full_valid", 128'(o_valid_m), 128'(1));
        chk("full_data", 128'(o_dataout), 128'h00000044_00000033_00000022_00000011);
        chk("full_keep", 128'(o_keep), 128'(4'b1111));
        chk("full_last", 128'(o_last_m), 128'(0));
        @(posedge i_clk); #1;
        chk("full_onecycle", 128'(o_valid_m), 128'(0));

        // Partial packet closed by last
        push_word(32'hA, 0); push_word(32'hB, 1);
        idle();
        chk("part_data", 128'(o_dataout), 128'h00000000_00000000_0000000B_0000000A);
        chk("part_keep", 128'(o_keep), 128'(4'b0011));
        chk("part_last", 128'(o_last_m), 128'(1));
        @(posedge i_clk); #1;

        // Backpressure hold for 5 cycles with a word waiting
        i_ready_m = 1'b0;
        push_word(32'hC1, 0); push_word(32'hC2, 0);
        push_word(32'hC3, 0); push_word(32'hC4, 0);
        i_datain = 32'hD1;
        for (int c = 0; c < 5; c++) begin
            chk("bp_ready", 128'(o_ready_s), 128'(0));
            chk("bp_data", 128'(o_dataout), 128'h000000C4_000000C3_000000C2_000000C1);
            @(posedge i_clk); #1;
        end
        i_ready_m = 1'b1;
        #1;
        chk("bp_release_ready", 128'(o_ready_s), 128'(1));
        push_word(32'hD1, 0); push_word(32'hD2, 0);
        push_word(32'hD3, 0); push_word(32'hD4, 0);
        idle();
        chk("bp_next_data", 128'(o_dataout), 128'h000000D4_000000D3_000000D2_000000D1);

        // Single-word packets: output reloads every cycle, valid stays high
        for (int k = 0; k < 3; k++) begin
            push_word(32'hF0 + DW'(k), 1);
            chk("reload_valid", 128'(o_valid_m), 128'(1));
            chk("reload_data", 128'(o_dataout), 128'(32'hF0 + k));
            chk("reload_keep", 128'(o_keep), 128'(4'b0001));
        end
        idle();

        // Eight words back to back
        for (int k = 0; k < 8; k++) push_word(32'h100 + DW'(k), 0);
        idle();
        chk("b2b_data", 128'(o_dataout), 128'h00000107_00000106_00000105_00000104);
        chk("b2b_valid", 128'(o_valid_m), 128'(1));
        @(posedge i_clk); #1;

        // Reset mid-packet
        push_word(32'hDEAD0001, 0); push_word(32'hDEAD0002, 0);
        idle();
        #2 i_rst = 1'b1;
        #1;
        chk("mid_rst_valid", 128'(o_valid_m), 128'(0));
        chk("mid_rst_data", 128'(o_dataout), 128'(0));
        chk("mid_rst_keep", 128'(o_keep), 128'(0));
        @(posedge i_clk); #1 i_rst = 1'b0;
        push_word(32'hE1, 0); push_word(32'hE2, 0);
        push_word(32'hE3, 0); push_word(32'hE4, 0);
        idle();
        chk("post_rst_data", 128'(o_dataout), 128'h000000E4_000000E3_000000E2_000000E1);
        chk("post_rst_keep", 128'(o_keep), 128'(4'b1111));

        // Random traffic through a depth-8 FIFO stand-in
        seq = 0;
        for (int c = 0; c < 500; c++) begin
            @(negedge i_clk);
            take = i_valid_s && o_ready_s;
            @(posedge i_clk); #1;
            if (take) void'(fq.pop_front());
            if (fq.size() < 8 && $urandom_range(0, 3) != 0) begin
                fword_t w;
                w.d = {16'(seq), 16'($urandom)};
                w.l = ($urandom_range(0, 4) == 0);
                fq.push_back(w);
                seq++;
            end
            i_valid_s = fq.size() > 0;
            i_datain  = (fq.size() > 0) ? fq[0].d : '0;
            i_last_s  = (fq.size() > 0) ? fq[0].l : 1'b0;
            i_ready_m = ($urandom_range(0, 3) != 0);
        end
        idle();
        i_ready_m = 1'b1;
        repeat (4) @(posedge i_clk);
        @(negedge i_clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
